// File: rtl/serial_paralelo_rx.sv
// rtl/serial_paralelo_rx.sv - 2-bit serial to {valid,data} word receiver with comma alignment
// Optional in-service realignment when SP_REALIGN_EN is defined.
module serial_paralelo_rx #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk16f,
    input  logic       reset,
    input  logic [1:0] serial_in,
    output logic [8:0] paralelo_out,
    output logic       word_strobe,
    output logic       active,
    output logic       realign
);

    typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    state_t     state, state_nx;
    logic [5:0] sr;
    logic [1:0] phase, phase_nx;
    logic [3:0] bc_cnt, bc_cnt_nx;
    logic [8:0] out_nx;
    logic       strobe_nx;
    logic [7:0] word_next;
    logic       is_comma;

    assign word_next = {sr, serial_in};
    assign is_comma  = (word_next == COMMA);

`ifdef SP_REALIGN_EN
    logic [3:0] mis_cnt, mis_cnt_nx;
    logic [1:0] mis_p, mis_p_nx;
    logic       mis_seen, mis_seen_nx;
    logic       realign_nx;
`endif

    always_comb begin
        state_nx  = state;
        phase_nx  = phase + 2'd1;
        bc_cnt_nx = bc_cnt;
        out_nx    = paralelo_out;
        strobe_nx = 1'b0;
`ifdef SP_REALIGN_EN
        mis_cnt_nx  = mis_cnt;
        mis_p_nx    = mis_p;
        mis_seen_nx = mis_seen;
        realign_nx  = 1'b0;
`endif
        unique case (state)
            SEARCH: begin
                if (is_comma) begin
                    phase_nx  = 2'd0;
                    bc_cnt_nx = 4'd1;
                    state_nx  = LOCKING;
                end
            end
            LOCKING: begin
                if (phase == 2'd3) begin
                    if (is_comma) begin
                        bc_cnt_nx = bc_cnt + 4'd1;
                        if (bc_cnt + 4'd1 == LOCK_N)
                            state_nx = ACTIVE;
                    end else begin
                        bc_cnt_nx = 4'd0;
                        state_nx  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (phase == 2'd3) begin
                    strobe_nx = 1'b1;
                    out_nx    = is_comma ? {1'b0, COMMA} : {1'b1, word_next};
                end
`ifdef SP_REALIGN_EN
                // One word period ends at phase 3; an off-phase comma must recur every period.
                if (phase == 2'd3) begin
                    if (!mis_seen)
                        mis_cnt_nx = 4'd0;
                    mis_seen_nx = 1'b0;
                end else if (is_comma) begin
                    mis_seen_nx = 1'b1;
                    if (mis_cnt != 4'd0 && mis_p == phase) begin
                        mis_cnt_nx = mis_cnt + 4'd1;
                    end else begin
                        mis_cnt_nx = 4'd1;
                        mis_p_nx   = phase;
                    end
                    if (mis_cnt_nx == LOCK_N) begin
                        phase_nx    = 2'd0;
                        realign_nx  = 1'b1;
                        mis_cnt_nx  = 4'd0;
                        mis_seen_nx = 1'b0;
                    end
                end
`endif
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_ff @(posedge clk16f or posedge reset) begin
        if (reset) begin
            state        <= SEARCH;
            sr           <= 6'd0;
            phase        <= 2'd0;
            bc_cnt       <= 4'd0;
            paralelo_out <= 9'h000;
            word_strobe  <= 1'b0;
            active       <= 1'b0;
        end else begin
            state        <= state_nx;
            sr           <= word_next[5:0];
            phase        <= phase_nx;
            bc_cnt       <= bc_cnt_nx;
            paralelo_out <= out_nx;
            word_strobe  <= strobe_nx;
            active       <= (state_nx == ACTIVE);
        end
    end

`ifdef SP_REALIGN_EN
    always_ff @(posedge clk16f or posedge reset) begin
        if (reset) begin
            mis_cnt  <= 4'd0;
            mis_p    <= 2'd0;
            mis_seen <= 1'b0;
            realign  <= 1'b0;
        end else begin
            mis_cnt  <= mis_cnt_nx;
            mis_p    <= mis_p_nx;
            mis_seen <= mis_seen_nx;
            realign  <= realign_nx;
        end
    end
`else
    assign realign = 1'b0;
`endif

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb/tb_serial_paralelo_rx.sv - self-checking bench for serial_paralelo_rx
module tb_serial_paralelo_rx;

    localparam logic [7:0] COMMA = 8'hBC;

    logic       clk16f = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] serial_in = 2'b00;
    logic [8:0] paralelo_out;
    logic       word_strobe;
    logic       active;
    logic       realign;

    int         tests = 0;
    int         fails = 0;
    logic [8:0] exp_out = 9'h000;

    typedef struct {
        logic [7:0] data;
        logic [8:0] out;
    } vec_t;
    vec_t vecs[6];

    serial_paralelo_rx dut (
        .clk16f(clk16f),
        .reset(reset),
        .serial_in(serial_in),
        .paralelo_out(paralelo_out),
        .word_strobe(word_strobe),
        .active(active),
        .realign(realign)
    );

    always #5 clk16f = ~clk16f;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Word-level rule: commas are the idle/invalid word, anything else is valid data.
    function automatic logic [8:0] model_word(input logic [7:0] w);
        return {(w != COMMA), w};
    endfunction

    task automatic tick(input logic [1:0] p);
        @(negedge clk16f);
        serial_in = p;
        @(posedge clk16f);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input bit strobe_exp, input bit active_exp,
                             input string tag);
        for (int i = 0; i < 4; i++) begin
            tick(w[7-2*i -: 2]);
            if (i == 3 && strobe_exp)
                exp_out = model_word(w);
            check({tag, " strobe"}, 32'(word_strobe), 32'(i == 3 && strobe_exp));
            check({tag, " out"}, 32'(paralelo_out), 32'(exp_out));
            check({tag, " realign"}, 32'(realign), 32'(0));
        end
        check({tag, " active"}, 32'(active), 32'(active_exp));
    endtask

    task automatic lock_seq(input string tag);
        for (int k = 1; k <= 4; k++)
            send_word(COMMA, 1'b0, (k == 4), tag);
    endtask

    task automatic do_reset();
        @(negedge clk16f);
        reset = 1'b1;
        serial_in = 2'b00;
        #1;
        check("rst out", 32'(paralelo_out), 32'(0));
        check("rst strobe", 32'(word_strobe), 32'(0));
        check("rst active", 32'(active), 32'(0));
        check("rst realign", 32'(realign), 32'(0));
        repeat (2) @(posedge clk16f);
        @(negedge clk16f);
        reset = 1'b0;
        exp_out = 9'h000;
    endtask

    initial begin
        logic [7:0] w;
        int         rcount;

        vecs = '{'{8'hFF, 9'h1FF}, '{8'h55, 9'h155}, '{8'h00, 9'h100},
                 '{8'hBC, 9'h0BC}, '{8'hBC, 9'h0BC}, '{8'h00, 9'h100}};

        do_reset();
        lock_seq("lock");
        send_word(8'hFF, 1'b1, 1'b1, "lock first");
        check("lock first value", 32'(paralelo_out), 32'(9'h1FF));

        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].data, 1'b1, 1'b1, "stream");
            check("stream table", 32'(paralelo_out), 32'(vecs[i].out));
        end

        for (int i = 0; i < 40; i++) begin
            w = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                w = COMMA;
            send_word(w, 1'b1, 1'b1, "random");
        end

        do_reset();
        tick(2'b01);
        lock_seq("slip");
        send_word(8'h55, 1'b1, 1'b1, "slip data");
        check("slip value", 32'(paralelo_out), 32'(9'h155));

        do_reset();
        for (int k = 0; k < 3; k++)
            send_word(COMMA, 1'b0, 1'b0, "fail lock");
        send_word(8'hA5, 1'b0, 1'b0, "fail lock a5");
        lock_seq("relock");
        send_word(8'h3C, 1'b1, 1'b1, "relock data");
        check("relock value", 32'(paralelo_out), 32'(9'h13C));

        tick(2'b10);
        tick(2'b01);
        @(negedge clk16f);
        reset = 1'b1;
        #1;
        check("midword active", 32'(active), 32'(0));
        check("midword out", 32'(paralelo_out), 32'(0));
        check("midword strobe", 32'(word_strobe), 32'(0));
        repeat (2) @(posedge clk16f);
        @(negedge clk16f);
        reset = 1'b0;
        exp_out = 9'h000;
        send_word(8'h42, 1'b0, 1'b0, "post reset");
        lock_seq("post reset lock");
        send_word(8'h42, 1'b1, 1'b1, "post reset data");

`ifdef SP_REALIGN_EN
        rcount = 0;
        tick(2'b01);
        check("slip realign", 32'(realign), 32'(0));
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                w = COMMA;
                tick(w[7-2*i -: 2]);
                if (realign)
                    rcount++;
                check("realign pulse", 32'(realign), 32'(k == 3 && i == 3));
                check("realign strobe", 32'(word_strobe), 32'(i == 2));
            end
        end
        check("realign count", 32'(rcount), 32'(1));
        check("realign active", 32'(active), 32'(1));
        exp_out = 9'h12F;
        check("realign last slipped word", 32'(paralelo_out), 32'(exp_out));
        send_word(8'h55, 1'b1, 1'b1, "realigned data");
        check("realigned value", 32'(paralelo_out), 32'(9'h155));
`else
        rcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick(2'(i));
            if (realign)
                rcount++;
        end
        check("realign tied low", 32'(rcount), 32'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
